// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
//   - DIV_* : divider FSM state encodings (2-bit, legacy-compatible values)
//   - MDU_WIDTH_DEFAULT : default operand/result width
package mdu_pkg;

  localparam int MDU_WIDTH_DEFAULT = 32;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_CALC = 2'b10;
  localparam logic [1:0] DIV_DONE = 2'b11;

endpackage

// File: rtl/mdu_abs.sv
// mdu_abs: conditional two's-complement negate.
//   val : input value
//   neg : 1 = output -val, 0 = pass val through
//   res : result, same width as val
// Used both to take operand magnitudes and to restore result signs.
module mdu_abs
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  // Negate or pass through.
  always_comb begin
    if (neg) begin
      res = ~val + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
  end

endmodule

// File: rtl/mdu_div.sv
// mdu_div: iterative restoring divider, signed (DIV) and unsigned (DIVU).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start_i, signed_i     : request / mode, sampled only in IDLE
//   cancel_i              : flush, aborts any operation and suppresses done_o
//   dividend_i, divisor_i : operands, latched on the accepting edge
//   ready_o               : high in IDLE
//   done_o                : one-cycle result-valid pulse (DONE state)
//   quotient_o, remainder_o, divzero_o : registered results, updated on DONE entry
// Configuration macro: MDU_DIV_ZERO_FAST_EN -- when defined, a zero divisor
// goes IDLE -> DONE directly instead of iterating WIDTH cycles.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             divzero_o
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] quot_r;       // dividend bits shift out MSB, quotient bits shift in LSB
  logic [WIDTH-1:0] rem_r;        // partial remainder (magnitude)
  logic [WIDTH-1:0] dvs_r;        // divisor magnitude
  logic [WIDTH-1:0] dvd_r;        // original dividend, returned as remainder on divide-by-zero
  logic             q_neg_r;
  logic             r_neg_r;
  logic             zero_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             divzero_r;

  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic             dvs_zero_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] quot_next_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Magnitudes are plain WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1).
  mdu_abs #(.WIDTH(WIDTH)) u_abs_dvd (
    .val (dividend_i),
    .neg (signed_i & dividend_i[WIDTH-1]),
    .res (dvd_mag_s)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_abs_dvs (
    .val (divisor_i),
    .neg (signed_i & divisor_i[WIDTH-1]),
    .res (dvs_mag_s)
  );

  // Sign fix-up works on the final-iteration values so results latch on the DONE-entry edge.
  mdu_abs #(.WIDTH(WIDTH)) u_fix_quot (
    .val (quot_next_s),
    .neg (q_neg_r),
    .res (quot_fix_s)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .val (rem_next_s),
    .neg (r_neg_r),
    .res (rem_fix_s)
  );

  assign dvs_zero_s = (divisor_i == ZERO_W);

  // One restoring shift-subtract step; diff_s[WIDTH] set means the trial subtract borrowed.
  always_comb begin
    rem_shift_s = {rem_r, quot_r[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    q_bit_s     = ~diff_s[WIDTH];
    if (q_bit_s) begin
      rem_next_s = diff_s[WIDTH-1:0];
    end else begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
    end
    quot_next_s = {quot_r[WIDTH-2:0], q_bit_s};
  end

  // FSM, datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= DIV_IDLE;
      cnt_r       <= {CW{1'b0}};
      quot_r      <= ZERO_W;
      rem_r       <= ZERO_W;
      dvs_r       <= ZERO_W;
      dvd_r       <= ZERO_W;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      zero_r      <= 1'b0;
      quotient_r  <= ZERO_W;
      remainder_r <= ZERO_W;
      divzero_r   <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start_i && !cancel_i) begin
            quot_r  <= dvd_mag_s;
            rem_r   <= ZERO_W;
            dvs_r   <= dvs_mag_s;
            dvd_r   <= dividend_i;
            q_neg_r <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            r_neg_r <= signed_i & dividend_i[WIDTH-1];
            zero_r  <= dvs_zero_s;
            cnt_r   <= {CW{1'b0}};
`ifdef MDU_DIV_ZERO_FAST_EN
            if (dvs_zero_s) begin
              state_r     <= DIV_DONE;
              quotient_r  <= ALL_ONES;
              remainder_r <= dividend_i;
              divzero_r   <= 1'b1;
            end else begin
              state_r <= DIV_CALC;
            end
`else
            state_r <= DIV_CALC;
`endif
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          if (cancel_i) begin
            state_r <= DIV_IDLE;
          end else begin
            quot_r <= quot_next_s;
            rem_r  <= rem_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
            if (cnt_r == LAST_CNT) begin
              state_r <= DIV_DONE;
              if (zero_r) begin
                quotient_r  <= ALL_ONES;
                remainder_r <= dvd_r;
                divzero_r   <= 1'b1;
              end else begin
                quotient_r  <= quot_fix_s;
                remainder_r <= rem_fix_s;
                divzero_r   <= 1'b0;
              end
            end else begin
              state_r <= DIV_CALC;
            end
          end
        end
        DIV_DONE: begin
          state_r <= DIV_IDLE;
        end
        default: begin
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

  assign ready_o     = (state_r == DIV_IDLE);
  // A cancel in the DONE cycle must hide the pulse in that same cycle.
  assign done_o      = (state_r == DIV_DONE) & ~cancel_i;
  assign quotient_o  = quotient_r;
  assign remainder_o = remainder_r;
  assign divzero_o   = divzero_r;

endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: directed self-checking bench for mdu_div at WIDTH=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mdu_div;

  localparam int W = 32;
`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         cancel_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         divzero_o;

  int checks = 0;
  int errors = 0;

  mdu_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .cancel_i    (cancel_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .divzero_o   (divzero_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for done_o, counting falling edges after the accepting edge (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      start_i = 1'b0;
      lat++;
    end while (!done_o && lat < 80);
  endtask

  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check_eq("ready_before_start", {63'd0, ready_o}, 64'd1);
    check_eq("done_before_start", {63'd0, done_o}, 64'd0);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat);
    int lat;
    start_op(sgn, a, b);
    wait_done(lat);
    check_eq({tag, "_done"}, {63'd0, done_o}, 64'd1);
    check_eq({tag, "_lat"}, 64'(lat), 64'(elat));
    check_eq({tag, "_quot"}, {32'd0, quotient_o}, {32'd0, eq});
    check_eq({tag, "_rem"}, {32'd0, remainder_o}, {32'd0, er});
    check_eq({tag, "_dz"}, {63'd0, divzero_o}, {63'd0, edz});
  endtask

  task automatic expect_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  task automatic check_results(input string tag, input logic [W-1:0] eq,
                               input logic [W-1:0] er, input logic edz);
    check_eq({tag, "_quot"}, {32'd0, quotient_o}, {32'd0, eq});
    check_eq({tag, "_rem"}, {32'd0, remainder_o}, {32'd0, er});
    check_eq({tag, "_dz"}, {63'd0, divzero_o}, {63'd0, edz});
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {63'd0, ready_o}, 64'd1);
    check_eq("rst_done", {63'd0, done_o}, 64'd0);
    check_results("rst", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Basic signed/unsigned cases
    run_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_div("u_ff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
    run_div("s_ff_10", 1'b1, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0, 33);

    // Most-negative / -1, then a back-to-back start in the cycle after done
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
    run_div("b2b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

    // Divide by zero in both modes
    run_div("u_dz", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, ZERO_LAT);
    run_div("s_dz", 1'b1, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, ZERO_LAT);

    // Cancel 10 cycles into CALC: results keep the divide-by-zero values
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    check_eq("cancel_calc_ready", {63'd0, ready_o}, 64'd1);
    check_eq("cancel_calc_done", {63'd0, done_o}, 64'd0);
    check_results("cancel_calc", 32'hFFFF_FFFF, 32'h1234, 1'b1);
    expect_no_done("cancel_calc_nodone", 40);

    // Cancel in the DONE cycle: pulse hidden, results latched on DONE entry untouched
    start_op(1'b0, 32'd50, 32'd5);
    wait_done(lat);
    check_eq("cancel_done_lat", 64'(lat), 64'd33);
    cancel_i = 1'b1;
    #1;
    check_eq("cancel_done_pulse", {63'd0, done_o}, 64'd0);
    @(negedge clk);
    cancel_i = 1'b0;
    check_eq("cancel_done_ready", {63'd0, ready_o}, 64'd1);
    check_results("cancel_done", 32'd10, 32'd0, 1'b0);
    expect_no_done("cancel_done_nodone", 5);

    // Start and cancel together in IDLE: start dropped
    @(negedge clk);
    start_i  = 1'b1;
    cancel_i = 1'b1;
    dividend_i = 32'd9;
    divisor_i  = 32'd3;
    @(negedge clk);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    check_eq("start_cancel_ready", {63'd0, ready_o}, 64'd1);
    expect_no_done("start_cancel_nodone", 40);

    // Reset mid-CALC, then a normal signed operation
    start_op(1'b1, 32'd77, 32'd5);
    repeat (5) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_ready", {63'd0, ready_o}, 64'd1);
    check_eq("midrst_done", {63'd0, done_o}, 64'd0);
    check_results("midrst", 32'h0, 32'h0, 1'b0);
    expect_no_done("midrst_nodone", 40);
    run_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving operand and result width (legal 8..64).
REQ-002 The module SHALL have the port `clk  in  1`: clock, all state on rising edge.
REQ-003 The module SHALL have the port `rst_n  in  1`: reset, synchronous, active-low.
REQ-004 The module SHALL have the port `start_i  in  1`: request a division, sampled only in IDLE.
REQ-005 The module SHALL have the port `signed_i  in  1`: 1 = signed (DIV), 0 = unsigned (DIVU), latched with start.
REQ-006 The module SHALL have the port `cancel_i  in  1`: pipeline flush, aborts any operation in progress.
REQ-007 The module SHALL have the ports `dividend_i  in  WIDTH` and `divisor_i  in  WIDTH`: operands, latched with start.
REQ-008 The module SHALL have the port `ready_o  out  1`: high in IDLE, i.e. a start will be accepted.
REQ-009 The module SHALL have the port `done_o  out  1`: one-cycle pulse, results valid.
REQ-010 The module SHALL have the ports `quotient_o  out  WIDTH` and `remainder_o  out  WIDTH`: registered results.
REQ-011 The module SHALL have the port `divzero_o  out  1`: registered flag, divisor was zero, valid with done_o.

Function
REQ-012 The divider SHALL use an FSM with states IDLE, CALC, and DONE, registered.
- IDLE -> CALC on start_i & !cancel_i.
- CALC -> DONE after WIDTH iterations.
- DONE -> IDLE unconditionally.
REQ-013 The accepting edge SHALL latch operands, mode, and sign info, and clear the iteration counter.
- start_i outside IDLE SHALL be ignored.
REQ-014 CALC SHALL perform one restoring shift-subtract iteration per cycle on magnitudes, producing one quotient bit MSB-first.
- The counter width is clog2(WIDTH)+1.
REQ-015 done_o SHALL be high exactly WIDTH+1 cycles after the accepting cycle, for exactly one cycle (the DONE state).
REQ-016 Signed mode:
- The quotient SHALL be negated when the operand signs differ.
- The remainder SHALL take the sign of the dividend.
- Magnitudes SHALL be computed in WIDTH bits unsigned, so a most-negative operand is handled without overflow.
REQ-017 Signed most-negative / -1 SHALL yield quotient = most-negative and remainder = 0, with no flag.
REQ-018 A divisor of 0 SHALL yield quotient = all ones, remainder = dividend, and divzero_o = 1, in both modes.
REQ-019 quotient_o, remainder_o, and divzero_o SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-020 cancel_i in CALC or DONE SHALL force IDLE on the next edge.
- No done_o pulse SHALL be produced (cancel in DONE suppresses the pulse combinationally).
- Result registers SHALL be left unchanged.
REQ-021 cancel_i and start_i together in IDLE: cancel SHALL win and the start SHALL be dropped.
REQ-022 Back-to-back: a start SHALL be accepted in the cycle ready_o returns high (the cycle after DONE).

Reset
REQ-023 On rst_n = 0 at an edge:
- The state SHALL become IDLE.
- The counter and all operand, partial, and result registers SHALL be cleared.
- done_o and divzero_o SHALL be 0; ready_o SHALL be 1.
REQ-024 Reset mid-CALC SHALL abandon the operation with no done_o pulse afterwards.

Configuration
REQ-025 Macro MDU_DIV_ZERO_FAST_EN selects the divide-by-zero latency.
- Defined: a zero divisor at accept SHALL go IDLE -> DONE directly, with done_o one cycle after the accepting cycle.
- Undefined: a zero divisor SHALL take the full WIDTH+1 latency.
- Results and divzero_o SHALL be identical either way.

Structure
REQ-026 Package mdu_pkg SHALL hold the FSM state encodings (DIV_IDLE=2'b00, DIV_CALC=2'b10, DIV_DONE=2'b11) and the default WIDTH constant.
REQ-027 Sub-module mdu_abs SHALL provide the conditional two's-complement negate.
- It SHALL be parametrised by WIDTH and instantiated for the operand magnitudes and the result sign fix-up.

Verification (WIDTH=32)
REQ-028 Signed 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1, divzero 0, done_o 33 cycles after the start cycle.
REQ-029 Unsigned 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF; the same operands signed -> quotient 0, remainder 0xFFFFFFFF.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; then an immediate back-to-back start is accepted in the cycle after done.
REQ-031 0x1234 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 0x1234, divzero_o 1; done at 1 cycle with MDU_DIV_ZERO_FAST_EN, at 33 cycles without.
REQ-032 Cancel 10 cycles into CALC, and separately cancel in the DONE cycle -> no done pulse, ready_o high next cycle, results still hold the prior operation's values.
REQ-033 rst_n low for one edge mid-CALC -> all outputs at reset values; the next start completes normally with correct results.
